// File: rtl/dmem_arbiter.sv
// Arbiter for the single-port data memory, shared by the CPU data port and the debug/loader port.
// The CPU wins by default, debug is forced through after MAX_WAIT denials, and a lock mode gives debug exclusive use.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_locked,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // state      | meaning
  // NORMAL     | CPU priority, debug forced after MAX_WAIT denials
  // LOCK_WAIT  | lock requested, draining reads / waiting for a CPU-free cycle
  // LOCKED     | debug owns the memory, CPU held
  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_LOCK_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_state_eff;
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_nxt;
  logic [3:0] w_cnt_eff;
  logic       r_rd_pend;
  logic       r_rd_owner;
  logic       w_force;
  logic       w_cpu_sel;
  logic       w_dbg_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_NORMAL;
      r_wait_cnt <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_rd_pend  <= mem_en & ~mem_we;
      r_rd_owner <= w_dbg_sel;
    end
  end

  // During reset the request path still works, arbitrated as NORMAL with an empty wait count.
  always_comb begin
    w_state_eff = reset ? ST_NORMAL : r_state;
    w_cnt_eff   = reset ? 4'd0 : r_wait_cnt;
    w_force     = (w_cnt_eff == MAX_WAIT_C) & dbg_req;
    w_cpu_sel   = (w_state_eff != ST_LOCKED) & cpu_req & ~w_force;
    w_dbg_sel   = ~w_cpu_sel;

    mem_en    = w_cpu_sel | dbg_req;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_sel) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_req) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end

    dbg_gnt   = dbg_req & w_dbg_sel;
    cpu_stall = cpu_req & ~w_cpu_sel;
  end

  always_comb begin
    w_wait_nxt  = 4'd0;
    w_state_nxt = r_state;

    if (dbg_req & ~dbg_gnt) begin
      w_wait_nxt = (r_wait_cnt >= MAX_WAIT_C) ? MAX_WAIT_C : r_wait_cnt + 4'd1;
    end

    case (r_state)
      ST_NORMAL: begin
        if (dbg_lock) w_state_nxt = ST_LOCK_WAIT;
      end
      ST_LOCK_WAIT: begin
        if (!dbg_lock)                      w_state_nxt = ST_NORMAL;
        else if (!r_rd_pend && !cpu_stall)  w_state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!dbg_lock) w_state_nxt = ST_NORMAL;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  always_comb begin
    cpu_rvalid = r_rd_pend & ~r_rd_owner;
    dbg_rvalid = r_rd_pend & r_rd_owner;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    dbg_locked = (r_state == ST_LOCKED);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: CPU reads, forced debug grants, lock entry/exit, reset and read routing.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid, dbg_locked;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_locked(dbg_locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
    tick;
    tick;
    #3;
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    chk("rst_dbg_locked", dbg_locked, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_mem_en", mem_en, 0);

    // CPU-only reads at 0x10
    tick;
    reset = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 'h10;
    #3;
    chk("t1_mem_en", mem_en, 1);
    chk("t1_stall", cpu_stall, 0);
    chk("t1_addr", mem_addr, 'h10);
    chk("t1_we", mem_we, 0);
    chk("t1_rvalid0", cpu_rvalid, 0);
    for (int i = 1; i <= 2; i++) begin
      tick;
      mem_rdata = 32'hA5A5_0000 + 32'(i);
      #3;
      chk("t1_rvalid", cpu_rvalid, 1);
      chk("t1_rdata", cpu_rdata, 32'hA5A5_0000 + 32'(i));
      chk("t1_dbg_rvalid", dbg_rvalid, 0);
      chk("t1_mem_en_n", mem_en, 1);
    end
    tick;
    cpu_req = 0; mem_rdata = 32'hA5A5_0003;
    #3;
    chk("t1_rvalid3", cpu_rvalid, 1);
    chk("t1_rdata3", cpu_rdata, 32'hA5A5_0003);
    chk("t1_idle_en", mem_en, 0);
    chk("t1_idle_addr", mem_addr, 0);

    // Contention: CPU stores vs debug reads, debug forced every fifth cycle
    for (int i = 1; i <= 10; i++) begin
      tick;
      cpu_req = 1; cpu_we = 1; cpu_addr = 'h100 + 32'(i); cpu_wdata = 32'(i);
      dbg_req = 1; dbg_we = 0; dbg_addr = 'h200;
      mem_rdata = 32'h1234_0000 + 32'(i);
      #3;
      chk("t2_gnt", dbg_gnt, (i == 5 || i == 10));
      chk("t2_stall", cpu_stall, (i == 5 || i == 10));
      chk("t2_addr", mem_addr, (i == 5 || i == 10) ? 'h200 : 'h100 + i);
      chk("t2_dbg_rvalid", dbg_rvalid, (i == 6));
      chk("t2_dbg_rdata", dbg_rdata, (i == 6) ? 32'h1234_0006 : 0);
      chk("t2_cpu_rvalid", cpu_rvalid, 0);
    end
    tick;
    cpu_req = 0; dbg_req = 0; mem_rdata = 32'hCAFE_0011;
    #3;
    chk("t2_dbg_rvalid_last", dbg_rvalid, 1);
    chk("t2_dbg_rdata_last", dbg_rdata, 32'hCAFE_0011);

    // Debug write with idle CPU
    tick;
    dbg_req = 1; dbg_we = 1; dbg_addr = 'h20; dbg_wdata = 32'hDEAD_BEEF;
    #3;
    chk("t3_gnt", dbg_gnt, 1);
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 'h20);
    chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);

    // Lock requested while a CPU read is outstanding
    tick;
    dbg_req = 0; dbg_we = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 'h40;
    #3;
    chk("t4a_dbg_rvalid", dbg_rvalid, 0);
    chk("t4a_stall", cpu_stall, 0);
    tick;
    cpu_req = 0; dbg_lock = 1; mem_rdata = 32'h0BAD_F00D;
    #3;
    chk("t4b_cpu_rvalid", cpu_rvalid, 1);
    chk("t4b_cpu_rdata", cpu_rdata, 32'h0BAD_F00D);
    chk("t4b_locked", dbg_locked, 0);
    tick;
    #3;
    chk("t4c_locked", dbg_locked, 0);
    tick;
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h50;
    #3;
    chk("t4d_locked", dbg_locked, 1);
    chk("t4d_stall", cpu_stall, 1);
    chk("t4d_mem_en", mem_en, 0);
    tick;
    dbg_req = 1; dbg_we = 1; dbg_addr = 'h44; dbg_wdata = 32'h5;
    #3;
    chk("t4e_stall", cpu_stall, 1);
    chk("t4e_gnt", dbg_gnt, 1);
    chk("t4e_addr", mem_addr, 'h44);
    tick;
    dbg_lock = 0; dbg_req = 0; dbg_we = 0;
    #3;
    chk("t4f_stall", cpu_stall, 1);
    chk("t4f_locked", dbg_locked, 1);
    tick;
    #3;
    chk("t4g_stall", cpu_stall, 0);
    chk("t4g_locked", dbg_locked, 0);
    chk("t4g_addr", mem_addr, 'h50);

    // Saturate wait count, then reset mid-read
    for (int j = 1; j <= 4; j++) begin
      tick;
      cpu_req = 1; cpu_we = 1; cpu_addr = 'h60; dbg_req = 1; dbg_we = 0; dbg_addr = 'h70;
      #3;
      chk("t5_pre_gnt", dbg_gnt, 0);
    end
    tick;
    reset = 1; cpu_we = 0;
    #3;
    chk("t5_rst_gnt", dbg_gnt, 0);
    chk("t5_rst_stall", cpu_stall, 0);
    chk("t5_rst_en", mem_en, 1);
    for (int k = 1; k <= 5; k++) begin
      tick;
      reset = 0; cpu_we = 1; mem_rdata = 32'h0000_FFFF;
      #3;
      if (k == 1) begin
        chk("t5_rvalid_dropped", cpu_rvalid, 0);
        chk("t5_rdata_zero", cpu_rdata, 0);
        chk("t5_locked", dbg_locked, 0);
      end
      chk("t5_gnt", dbg_gnt, (k == 5));
    end

    // Interleaved CPU then debug reads
    tick;
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h4; dbg_req = 0; mem_rdata = 32'h0000_0077;
    #3;
    chk("t6p_dbg_rvalid", dbg_rvalid, 1);
    chk("t6p_dbg_rdata", dbg_rdata, 32'h0000_0077);
    chk("t6p_addr", mem_addr, 'h4);
    tick;
    cpu_req = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 'h8; mem_rdata = 32'h1111_0004;
    #3;
    chk("t6q_cpu_rvalid", cpu_rvalid, 1);
    chk("t6q_cpu_rdata", cpu_rdata, 32'h1111_0004);
    chk("t6q_dbg_rvalid", dbg_rvalid, 0);
    chk("t6q_dbg_rdata", dbg_rdata, 0);
    chk("t6q_gnt", dbg_gnt, 1);
    chk("t6q_addr", mem_addr, 'h8);
    tick;
    dbg_req = 0; mem_rdata = 32'h2222_0008;
    #3;
    chk("t6r_dbg_rvalid", dbg_rvalid, 1);
    chk("t6r_dbg_rdata", dbg_rdata, 32'h2222_0008);
    chk("t6r_cpu_rvalid", cpu_rvalid, 0);
    chk("t6r_cpu_rdata", cpu_rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
